seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_if.sv | 25 ++
 rtl/seg7_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Display bus between the CPU display_7segs port and the seven-segment scanner.
// master: the CPU side driving digits/controls; slave: the scanner driving the board pins.
interface seg7_if #(
    parameter int unsigned DIGITS = 8
);
    logic [4*DIGITS-1:0] in_data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_mask;
    logic                lz_blank;
    logic                freeze;
    logic [6:0]          display_data;
    logic                display_dp;
    logic [DIGITS-1:0]   display_en;
    logic                frame_tick;

    modport master (
        output in_data, dp_in, digit_mask, lz_blank, freeze,
        input  display_data, display_dp, display_en, frame_tick
    );

    modport slave (
        input  in_data, dp_in, digit_mask, lz_blank, freeze,
        output display_data, display_dp, display_en, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-synchronised shadow,
// leading-zero blanking, per-digit mask/dp and a blanking guard at the start of each slot.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 64,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic  clk_board,
    input  logic  rst_n,
    seg7_if.slave bus
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic        POL   = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_dp;
    logic                load_pend;

    logic                tick_c;
    logic                wrap_c;
    logic                load_c;
    logic [DIGITS-1:0]   blank_c;
    logic [DIGITS-1:0]   sel_c;
    logic [3:0]          nib_c;
    logic                dp_c;
    logic                lit_c;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick_c = (cnt == CNT_W'(SCAN_DIV - 1));
    assign wrap_c = tick_c && (idx == IDX_W'(DIGITS - 1));
    // freeze is only looked at on the frame wrap, so a frame is never torn
    assign load_c = (wrap_c && !bus.freeze) || load_pend;

    // Slot prescaler and digit index
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            load_pend <= 1'b1;
        end else begin
            load_pend <= 1'b0;
            if (tick_c) begin
                cnt <= '0;
                idx <= wrap_c ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shadow copy of the displayed value
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else if (load_c) begin
            shadow_data <= bus.in_data;
            shadow_dp   <= bus.dp_in;
        end
    end

    // Leading-zero blanking from the top digit down; digit selection for the current slot
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_c  = '0;
        sel_c    = '0;
        nib_c    = 4'h0;
        dp_c     = 1'b0;
        lit_c    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (shadow_data[4*i +: 4] == 4'h0);
            blank_c[i] = bus.lz_blank && (i != 0) && all_zero;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_c[i] = 1'b1;
                nib_c    = shadow_data[4*i +: 4];
                dp_c     = shadow_dp[i];
                lit_c    = bus.digit_mask[i] && !blank_c[i];
            end
        end
        lit_c = lit_c && (cnt >= CNT_W'(BLANK_CYC));
    end

    // Registered pin drivers with output polarity applied
    always_ff @(posedge clk_board or negedge rst_n) begin
        if (!rst_n) begin
            bus.display_en   <= {DIGITS{POL}};
            bus.display_data <= {7{POL}};
            bus.display_dp   <= POL;
            bus.frame_tick   <= 1'b0;
        end else begin
            bus.frame_tick <= wrap_c;
            if (lit_c) begin
                bus.display_en   <= {DIGITS{POL}} ^ sel_c;
                bus.display_data <= {7{POL}} ^ hex_decode(nib_c);
                bus.display_dp   <= POL ^ dp_c;
            end else begin
                bus.display_en   <= {DIGITS{POL}};
                bus.display_data <= {7{POL}};
                bus.display_dp   <= POL;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low outputs.
module tb_seg7_scan_ctrl;
    logic clk_board;
    logic rst_n;
    int   errors;
    int   checks;

    seg7_if #(.DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(1)
    ) dut (
        .clk_board(clk_board),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk_board = 1'b0;
    always #5 clk_board = ~clk_board;

    // Segment words (active-low) packed {digit3, digit2, digit1, digit0}
    localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] SEG_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] SEG_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [12:0] IDLE     = {4'hF, 7'h7F, 1'b1, 1'b0};

    function automatic logic [12:0] pins();
        return {bus.display_en, bus.display_data, bus.display_dp, bus.frame_tick};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full frame starting right after a wrap: slot position 0 is the blanking guard
    task automatic check_frame(input string tag, input logic [3:0] lit,
                               input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] e_en;
        logic [6:0] e_seg;
        logic       e_dp;
        int         j;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_board);
            j     = c / 4;
            e_en  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if ((c % 4) != 0 && lit[j]) begin
                e_en  = ~(4'b0001 << j);
                e_seg = segs[j*7 +: 7];
                e_dp  = dps[j];
            end
            chk($sformatf("%s c%0d", tag, c), 32'(pins()),
                32'({e_en, e_seg, e_dp, (c == 15)}));
        end
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_board);
            n++;
        end while (!bus.frame_tick && n < 64);
        chk({tag, " wait_frame"}, 32'(bus.frame_tick), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.in_data    = 16'h1234;
        bus.dp_in      = 4'b0000;
        bus.digit_mask = 4'hF;
        bus.lz_blank   = 1'b0;
        bus.freeze     = 1'b0;
        repeat (2) @(negedge clk_board);
        chk("reset idle", 32'(pins()), 32'(IDLE));

        // basic scan of 1234
        rst_n = 1'b1;
        check_frame("t2 first", 4'hF, SEG_1234, 4'hF);
        check_frame("t2 second", 4'hF, SEG_1234, 4'hF);

        // leading-zero blanking
        bus.lz_blank = 1'b1;
        bus.in_data  = 16'h0050;
        wait_frame("t3a");
        check_frame("t3 0050", 4'b0011, SEG_0050, 4'hF);
        bus.in_data = 16'h0000;
        wait_frame("t3b");
        check_frame("t3 0000", 4'b0001, SEG_0000, 4'hF);

        // freeze holds the shadow; release takes effect on the following wrap only
        bus.lz_blank = 1'b0;
        bus.in_data  = 16'h1234;
        wait_frame("t4a");
        check_frame("t4 pre", 4'hF, SEG_1234, 4'hF);
        repeat (5) @(negedge clk_board);
        bus.freeze = 1'b1;
        repeat (3) @(negedge clk_board);
        bus.in_data = 16'hABCD;
        wait_frame("t4b");
        check_frame("t4 frozen1", 4'hF, SEG_1234, 4'hF);
        check_frame("t4 frozen2", 4'hF, SEG_1234, 4'hF);
        bus.freeze = 1'b0;
        check_frame("t4 old", 4'hF, SEG_1234, 4'hF);
        check_frame("t4 new", 4'hF, SEG_ABCD, 4'hF);

        // digit mask and decimal point
        bus.in_data    = 16'h1234;
        bus.digit_mask = 4'b0101;
        bus.dp_in      = 4'b0001;
        wait_frame("t5");
        check_frame("t5 mask", 4'b0101, SEG_1234, 4'b1110);
        bus.digit_mask = 4'hF;
        bus.dp_in      = 4'b0000;

        // frame_tick period over ten frames (a wide pulse shows up as a short period)
        wait_frame("t6");
        for (int f = 0; f < 10; f++) begin
            n = 0;
            do begin
                @(negedge clk_board);
                n++;
            end while (!bus.frame_tick && n < 64);
            chk($sformatf("t6 period f%0d", f), 32'(n), 32'd16);
        end

        // asynchronous reset in the middle of a lit slot
        repeat (2) @(negedge clk_board);
        chk("t1 lit before reset", 32'(pins()), 32'({4'hE, 7'h19, 1'b1, 1'b0}));
        #2 rst_n = 1'b0;
        #1 chk("t1 async reset", 32'(pins()), 32'(IDLE));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_board);
            chk($sformatf("t1 held c%0d", c), 32'(pins()), 32'(IDLE));
        end
        rst_n = 1'b1;
        check_frame("t1 restart", 4'hF, SEG_1234, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
